tiny_mips_core_p: RTL and testbench
===================================

TINY_MIPS_CORE_P -- requirements
Module: tiny_mips_core_p

Interface
REQ-001 Parameter DW, default 16: datapath and register width; must be at least 16.
REQ-002 Parameter AW, default 8: memory address width; PC width.
REQ-003 Reset is rst, asynchronous, active-high; the clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 mem_req  out  1  memory transaction request.
REQ-007 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  out  AW  transaction address.
REQ-009 mem_wdata  out  DW  store data.
REQ-010 mem_rdata  in  DW  read data; valid in the mem_ack cycle.
REQ-011 mem_ack  in  1  transaction complete; ignored while mem_req=0.
REQ-012 halted  out  1  core stopped on HALT.
REQ-013 pc  out  AW  current PC.

Function
REQ-014 The core SHALL be an unpipelined multi-cycle machine with states FETCH, DECODE, EXEC, MEM and HALT, and eight DW-bit registers R0-R7 plus T1, T2 and IW.
REQ-015 All outputs SHALL be registered; mem_req/we/addr/wdata SHALL stay stable from assertion through the cycle mem_ack=1 is sampled, and mem_req SHALL drop the following cycle.
REQ-016 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on ack latch IW=mem_rdata[15:0] -> DECODE; with no ack, stay in FETCH (unbounded wait).
REQ-017 DECODE: T1=R[IW[8:6]] (branches: R[IW[11:9]]); T2=R[IW[5:3]] (branches: R[IW[8:6]]) -> EXEC.
REQ-018 Fields: op=IW[15:12], rd=IW[11:9], imm6=IW[5:0], imm9=IW[8:0], imm12=IW[11:0].
REQ-019 EXEC, opcode 0 ADD: rd=T1+T2 mod 2^DW.
REQ-020 EXEC, opcode 1 ADDI: rd=T1+sext(imm6).
REQ-021 EXEC, opcode 2 MUL: rd=low DW bits of T1*T2.
REQ-022 EXEC, opcode 3 SRL: T2<DW -> rd=T1>>T2; DW<=T2<2DW -> rd=T1<<(T2-DW); otherwise rd=0.
REQ-023 EXEC, opcodes 6 CP / 7 CPI: rd=R[IW[8:6]] or zext(imm9).
REQ-024 EXEC, opcodes 8/9/A BEQ/BLT/BGT: unsigned T1 vs T2; taken -> PC+sext(imm6); else PC+1.
REQ-025 EXEC, opcode B JMP: PC=PC+sext(imm12) truncated to AW.
REQ-026 EXEC, opcode F HALT: enter HALT; undefined opcodes act as NOP.
REQ-027 After all non-memory, non-HALT opcodes, EXEC SHALL return to FETCH with PC+1 unless a branch or jump redirects it; each such instruction takes 3 cycles plus fetch wait cycles.
REQ-028 Opcodes 4 LD and 5 ST SHALL go EXEC -> MEM with mem_addr=(T1+zext(imm6)) mod 2^AW.
REQ-029 LD SHALL write rd=mem_rdata on ack; ST SHALL drive mem_we=1, mem_wdata=R[rd]; both then PC+1 -> FETCH.
REQ-030 All PC arithmetic SHALL wrap modulo 2^AW.
REQ-031 HALT SHALL hold halted=1 and mem_req=0, and ignore mem_ack, until reset.
REQ-032 Exactly one register write per instruction SHALL occur; if rd equals a source, the old value is used as the operand.

Reset
REQ-033 On rst: state=FETCH, PC=0, IW=T1=T2=0, R0-R7=0, mem_req=mem_we=0, mem_addr=0, mem_wdata=0, halted=0.
REQ-034 rst mid-transaction SHALL drop mem_req immediately, and the core SHALL discard any later ack.
REQ-035 After rst release, the first FETCH of address 0 SHALL be issued on the first rising clk edge.

Verification (DW=16, AW=8)
REQ-036 Zero-latency ack, program CPI R1,5; CPI R2,7; ADD R3,R1,R2; HALT -> R3=12, halted=1 after 12 cycles.
REQ-037 Ack delayed 3 cycles each fetch -> mem_addr/req remain stable throughout, and results are identical to REQ-036.
REQ-038 ST R3,[R0+10] then LD R4,[R0+10] -> write cycle has we=1, addr=0x0A, wdata=12; R4=12.
REQ-039 PC=0xFF with BEQ R1,R1,+2 -> PC=0x01; JMP -2 at PC=0x00 -> PC=0xFE.
REQ-040 SRL with T1=0x8001: T2=1 -> 0x4000; T2=17 -> 0x0002; T2=40 -> 0.
REQ-041 rst asserted during LD MEM wait, then a late ack -> req drops immediately, R4 is unchanged (0), and the core refetches from PC=0.

Source files
------------

// File: rtl/tiny_mips_core_p.sv
// tiny_mips_core_p: unpipelined multi-cycle 16-bit-instruction core.
// Each instruction walks FETCH -> DECODE -> EXEC (-> MEM for LD/ST).
// All memory-interface outputs are registered and held until the ack is sampled.
//
// Memory handshake: the core raises mem_req together with mem_we/mem_addr/mem_wdata
// and keeps all four frozen until it samples mem_ack=1 on a rising edge; mem_req
// drops on the following cycle. mem_ack is ignored whenever mem_req is low.
module tiny_mips_core_p #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic [AW-1:0] pc,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_SRL  = 4'h3;
    localparam logic [3:0] OP_LD   = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_CP   = 4'h6;
    localparam logic [3:0] OP_CPI  = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BLT  = 4'h9;
    localparam logic [3:0] OP_BGT  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [DW-1:0] DW_L  = DW'(DW);
    localparam logic [DW-1:0] DW2_L = DW'(2 * DW);

    state_t          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [15:0]     iw_q, iw_d;
    logic [DW-1:0]   t1_q, t1_d;
    logic [DW-1:0]   t2_q, t2_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            halted_q, halted_d;
    logic [DW-1:0]   regs_q [8];

    logic            rf_we;
    logic [2:0]      rf_waddr;
    logic [DW-1:0]   rf_wdata;

    // Instruction fields
    logic [3:0]      op;
    logic [2:0]      rd;
    logic [2:0]      rs;
    logic [2:0]      rt;
    logic [5:0]      imm6;
    logic [8:0]      imm9;
    logic [11:0]     imm12;
    logic            is_branch;

    assign op        = iw_q[15:12];
    assign rd        = iw_q[11:9];
    assign rs        = iw_q[8:6];
    assign rt        = iw_q[5:3];
    assign imm6      = iw_q[5:0];
    assign imm9      = iw_q[8:0];
    assign imm12     = iw_q[11:0];
    assign is_branch = (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BGT);

    // Datapath helpers, all operating on the latched T1/T2 so rd==source reads old values
    logic [DW-1:0]   add_res;
    logic [DW-1:0]   addi_res;
    logic [DW-1:0]   mul_res;
    logic [DW-1:0]   shift_res;
    logic [AW-1:0]   pc_inc;
    logic [AW-1:0]   pc_br;
    logic [AW-1:0]   pc_jmp;
    logic [AW-1:0]   ea;
    logic [AW-1:0]   next_pc;

    assign add_res  = t1_q + t2_q;
    assign addi_res = t1_q + DW'($signed(imm6));
    assign mul_res  = t1_q * t2_q;
    assign pc_inc   = pc_q + AW'(1);
    assign pc_br    = pc_q + AW'($signed(imm6));
    assign pc_jmp   = pc_q + AW'($signed(imm12));
    assign ea       = AW'(t1_q) + AW'(imm6);

    // Combined shifter: right shift below DW, left shift by (T2-DW) up to 2*DW, else zero
    always_comb begin
        shift_res = '0;
        if (t2_q < DW_L) begin
            shift_res = t1_q >> t2_q;
        end else if (t2_q < DW2_L) begin
            shift_res = t1_q << (t2_q - DW_L);
        end
    end

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        iw_d        = iw_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        rf_we       = 1'b0;
        rf_waddr    = rd;
        rf_wdata    = '0;
        next_pc     = pc_inc;

        unique case (state_q)
            S_FETCH: begin
                if (!mem_req_q) begin
                    // Issue the fetch (after reset or after a MEM completion)
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (mem_ack) begin
                    iw_d      = mem_rdata[15:0];
                    mem_req_d = 1'b0;
                    state_d   = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_branch) begin
                    t1_d = regs_q[rd];
                    t2_d = regs_q[rs];
                end else begin
                    t1_d = regs_q[rs];
                    t2_d = regs_q[rt];
                end
                state_d = S_EXEC;
            end

            S_EXEC: begin
                case (op)
                    OP_ADD:  begin rf_we = 1'b1; rf_wdata = add_res;   end
                    OP_ADDI: begin rf_we = 1'b1; rf_wdata = addi_res;  end
                    OP_MUL:  begin rf_we = 1'b1; rf_wdata = mul_res;   end
                    OP_SRL:  begin rf_we = 1'b1; rf_wdata = shift_res; end
                    OP_CP:   begin rf_we = 1'b1; rf_wdata = t1_q;      end
                    OP_CPI:  begin rf_we = 1'b1; rf_wdata = DW'(imm9); end
                    OP_BEQ:  if (t1_q == t2_q) next_pc = pc_br;
                    OP_BLT:  if (t1_q <  t2_q) next_pc = pc_br;
                    OP_BGT:  if (t1_q >  t2_q) next_pc = pc_br;
                    OP_JMP:  next_pc = pc_jmp;
                    default: ;
                endcase

                if ((op == OP_LD) || (op == OP_ST)) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = (op == OP_ST);
                    mem_addr_d  = ea;
                    mem_wdata_d = regs_q[rd];
                    state_d     = S_MEM;
                end else if (op == OP_HALT) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    // Launch the next fetch directly so a plain instruction costs 3 cycles
                    pc_d       = next_pc;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = next_pc;
                    state_d    = S_FETCH;
                end
            end

            S_MEM: begin
                if (mem_req_q && mem_ack) begin
                    if (!mem_we_q) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = S_FETCH;
                end
            end

            S_HALT: begin
                mem_req_d = 1'b0;
                halted_d  = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase
    end

    // State, PC, instruction/operand latches and memory-interface outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            iw_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            iw_q        <= iw_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    // Register file: a single write port, at most one write per instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign pc        = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tiny_mips_core_p.sv
// Directed testbench for tiny_mips_core_p (DW=16, AW=8) with a behavioural
// memory that acks after a programmable number of wait cycles.
module tb_tiny_mips_core_p;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        halted;
    logic [7:0]  pc;
    logic [2:0]  dbg_state;

    tiny_mips_core_p #(.DW(16), .AW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .pc        (pc),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    int          lat;
    logic        block_ld;
    logic        late_ack;
    logic        load_en;
    logic        clr;
    logic [7:0]  load_addr;
    logic [15:0] load_data;
    logic [15:0] mem [256];
    int          wait_cnt;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = (mem_req && (wait_cnt >= lat) &&
                        !(block_ld && !mem_we && (mem_addr == 8'd10))) || late_ack;

    always @(posedge clk) begin
        if (!mem_req || mem_ack) wait_cnt <= 0;
        else                     wait_cnt <= wait_cnt + 1;
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (!rst && mem_req && mem_we && mem_ack) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- bus monitor / recorder ----------------
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          mem_cnt;
    logic        m_we;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;
    int          viol;
    logic        prev_req, prev_ack, prev_we;
    logic [7:0]  prev_addr;
    logic [15:0] prev_wdata;

    always @(posedge clk) begin
        if (rst) begin
            got_q.delete();
            mem_cnt  <= 0;
            viol     <= 0;
            prev_req <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (mem_req && mem_ack && !mem_we && dbg_state == 3'd0) got_q.push_back(mem_addr);
            if (mem_req && mem_ack && dbg_state == 3'd3) begin
                if (mem_cnt == 0) begin
                    m_we    <= mem_we;
                    m_addr  <= mem_addr;
                    m_wdata <= mem_wdata;
                end
                mem_cnt <= mem_cnt + 1;
            end
            if (prev_req && !prev_ack &&
                (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_we !== prev_we ||
                 mem_wdata !== prev_wdata)) viol <= viol + 1;
            if (prev_req && prev_ack && mem_req) viol <= viol + 1;
            prev_req   <= mem_req;
            prev_ack   <= mem_ack;
            prev_we    <= mem_we;
            prev_addr  <= mem_addr;
            prev_wdata <= mem_wdata;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_fetches(input string tag);
        check({tag, "_nfetch"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_fetch"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    // ---------------- instruction encoders ----------------
    function automatic logic [15:0] f_rrr(input logic [3:0] o, input logic [2:0] d,
                                          input logic [2:0] s, input logic [2:0] t);
        return {o, d, s, t, 3'b000};
    endfunction

    function automatic logic [15:0] f_ri6(input logic [3:0] o, input logic [2:0] a,
                                          input logic [2:0] b, input logic [5:0] i6);
        return {o, a, b, i6};
    endfunction

    function automatic logic [15:0] f_cpi(input logic [2:0] d, input logic [8:0] i9);
        return {4'h7, d, i9};
    endfunction

    function automatic logic [15:0] f_jmp(input logic [11:0] i12);
        return {4'hB, i12};
    endfunction

    localparam logic [15:0] HALT_I = 16'hF000;

    // ---------------- driver tasks ----------------
    task automatic start(input int l);
        @(negedge clk);
        rst      = 1'b1;
        lat      = l;
        block_ld = 1'b0;
        late_ack = 1'b0;
        clr      = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        exp_q.delete();
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        load_addr = a;
        load_data = d;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input int budget, output int cyc, output int first);
        cyc   = 0;
        first = -1;
        while (!halted && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_req && first < 0) first = cyc;
        end
    endtask

    // ---------------- stimulus ----------------
    int cyc, first, found;

    initial begin
        rst = 1'b1; lat = 0; block_ld = 1'b0; late_ack = 1'b0;
        load_en = 1'b0; clr = 1'b0; load_addr = '0; load_data = '0;

        // Test 1: basic program, zero-latency ack
        start(0);
        load(8'd0, f_cpi(3'd1, 9'd5));
        load(8'd1, f_cpi(3'd2, 9'd7));
        load(8'd2, f_rrr(4'h0, 3'd3, 3'd1, 3'd2));
        load(8'd3, HALT_I);
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 8'd0);
        check("rst_wdata", mem_wdata, 16'd0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, 8'd0);
        check("rst_state", dbg_state, 3'd0);
        release_rst();
        @(posedge clk); #1;
        check("first_fetch_req", mem_req, 1'b1);
        check("first_fetch_addr", mem_addr, 8'd0);
        cyc = 1; first = 1;
        while (!halted && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        check("t1_halted", halted, 1'b1);
        check("t1_cycles", cyc - first, 12);
        check("t1_r1", dut.regs_q[1], 16'd5);
        check("t1_r2", dut.regs_q[2], 16'd7);
        check("t1_r3", dut.regs_q[3], 16'd12);
        check("t1_pc", pc, 8'd3);
        late_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("halt_req", mem_req, 1'b0);
        check("halt_hold", halted, 1'b1);
        check("halt_state", dbg_state, 3'd4);
        check("halt_pc", pc, 8'd3);
        late_ack = 1'b0;
        check("t1_stable", viol, 0);

        // Test 2: same program, 3 wait cycles on every fetch
        start(3);
        load(8'd0, f_cpi(3'd1, 9'd5));
        load(8'd1, f_cpi(3'd2, 9'd7));
        load(8'd2, f_rrr(4'h0, 3'd3, 3'd1, 3'd2));
        load(8'd3, HALT_I);
        release_rst();
        run_to_halt(400, cyc, first);
        check("t2_halted", halted, 1'b1);
        check("t2_cycles", cyc - first, 24);
        check("t2_r3", dut.regs_q[3], 16'd12);
        check("t2_stable", viol, 0);

        // Test 3: store/load round trip plus ADDI(-1), MUL and rd==source
        start(1);
        load(8'd0, f_cpi(3'd1, 9'd5));
        load(8'd1, f_cpi(3'd2, 9'd7));
        load(8'd2, f_rrr(4'h0, 3'd3, 3'd1, 3'd2));
        load(8'd3, f_ri6(4'h5, 3'd3, 3'd0, 6'd10));
        load(8'd4, f_ri6(4'h4, 3'd4, 3'd0, 6'd10));
        load(8'd5, f_ri6(4'h1, 3'd2, 3'd2, 6'h3F));
        load(8'd6, f_rrr(4'h2, 3'd5, 3'd1, 3'd2));
        load(8'd7, f_rrr(4'h0, 3'd1, 3'd1, 3'd1));
        load(8'd8, HALT_I);
        release_rst();
        run_to_halt(600, cyc, first);
        check("t3_halted", halted, 1'b1);
        check("t3_mem_cnt", mem_cnt, 2);
        check("st_we", m_we, 1'b1);
        check("st_addr", m_addr, 8'h0A);
        check("st_wdata", m_wdata, 16'd12);
        check("ld_r4", dut.regs_q[4], 16'd12);
        check("addi_neg_r2", dut.regs_q[2], 16'd6);
        check("mul_r5", dut.regs_q[5], 16'd30);
        check("add_self_r1", dut.regs_q[1], 16'd10);
        check("t3_pc", pc, 8'd8);
        check("t3_stable", viol, 0);

        // Test 4a: JMP -1 from 0 wraps to 0xFF, BEQ +2 at 0xFF wraps to 0x01, BLT not taken
        start(0);
        load(8'h00, f_jmp(12'hFFF));
        load(8'hFF, f_ri6(4'h8, 3'd1, 3'd1, 6'd2));
        load(8'h01, f_ri6(4'h9, 3'd1, 3'd1, 6'd5));
        load(8'h02, HALT_I);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h01); exp_q.push_back(8'h02);
        release_rst();
        run_to_halt(200, cyc, first);
        check("t4a_halted", halted, 1'b1);
        check("t4a_pc", pc, 8'h02);
        check_fetches("t4a");

        // Test 4b: JMP -2 at 0x00 lands on 0xFE
        start(0);
        load(8'h00, f_jmp(12'hFFE));
        load(8'hFE, HALT_I);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFE);
        release_rst();
        run_to_halt(200, cyc, first);
        check("t4b_halted", halted, 1'b1);
        check("t4b_pc", pc, 8'hFE);
        check_fetches("t4b");

        // Test 5: shifter boundaries on 0x8001, CP, BGT taken skips one instruction
        start(0);
        load(8'd0,  f_cpi(3'd1, 9'd1));
        load(8'd1,  f_cpi(3'd3, 9'd31));
        load(8'd2,  f_rrr(4'h3, 3'd4, 3'd1, 3'd3));
        load(8'd3,  f_ri6(4'h1, 3'd4, 3'd4, 6'd1));
        load(8'd4,  f_cpi(3'd5, 9'd1));
        load(8'd5,  f_cpi(3'd6, 9'd17));
        load(8'd6,  f_cpi(3'd7, 9'd40));
        load(8'd7,  f_rrr(4'h3, 3'd5, 3'd4, 3'd5));
        load(8'd8,  f_rrr(4'h3, 3'd6, 3'd4, 3'd6));
        load(8'd9,  f_rrr(4'h3, 3'd7, 3'd4, 3'd7));
        load(8'd10, f_ri6(4'h6, 3'd2, 3'd4, 6'd0));
        load(8'd11, f_ri6(4'hA, 3'd4, 3'd1, 6'd2));
        load(8'd12, f_cpi(3'd2, 9'd0));
        load(8'd13, HALT_I);
        release_rst();
        run_to_halt(400, cyc, first);
        check("t5_halted", halted, 1'b1);
        check("srl_r4_0x8001", dut.regs_q[4], 16'h8001);
        check("srl_t2_1", dut.regs_q[5], 16'h4000);
        check("srl_t2_17", dut.regs_q[6], 16'h0002);
        check("srl_t2_40", dut.regs_q[7], 16'h0000);
        check("cp_bgt_r2", dut.regs_q[2], 16'h8001);
        check("t5_pc", pc, 8'd13);

        // Test 6: reset while the LD waits in MEM, then a stray late ack
        start(0);
        load(8'd0, f_cpi(3'd1, 9'd5));
        load(8'd1, f_ri6(4'h5, 3'd1, 3'd0, 6'd10));
        load(8'd2, f_ri6(4'h4, 3'd4, 3'd0, 6'd10));
        load(8'd3, HALT_I);
        block_ld = 1'b1;
        release_rst();
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(posedge clk); #1;
            if (mem_req && !mem_we && mem_addr == 8'd10) found = 1;
        end
        check("t6_ld_seen", found, 1);
        repeat (2) @(posedge clk);
        #1;
        check("t6_ld_wait_req", mem_req, 1'b1);
        check("t6_ld_wait_r4", dut.regs_q[4], 16'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_rst_req_drop", mem_req, 1'b0);
        check("t6_rst_pc", pc, 8'd0);
        check("t6_rst_state", dbg_state, 3'd0);
        late_ack = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        late_ack = 1'b0;
        check("t6_refetch_state", dbg_state, 3'd0);
        check("t6_refetch_req", mem_req, 1'b1);
        check("t6_refetch_addr", mem_addr, 8'd0);
        check("t6_r4_unchanged", dut.regs_q[4], 16'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the bench never hangs
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
